mem_copy_ctrl: RTL and testbench
================================

// Module: mem_copy_ctrl
// PURPOSE
//  Sequencer that copies a block of bytes inside the 128-byte decoder_rc space (ROM half 0x00-0x3F, SRAM half 0x40-0x7F).
//  Owns decoder_rc's single address/we/din port; one word is moved per 3-cycle RD/CAP/WR slot.
//  Start/busy/done handshake to a host FSM. Destination in ROM is an error. Reports an 8-bit running checksum of the bytes written.
// PARAMETERS
//  AW  7  memory address width; bit AW-1 selects SRAM (1) / ROM (0)
//  DW  8  memory data width
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst_n      in   1   asynchronous active-low reset
//  start      in   1   request copy; sampled only in IDLE
//  src_addr   in   AW  first source address (ROM or SRAM)
//  dst_addr   in   AW  first destination address
//  len        in   AW  word count; 0 = no-op
//  busy       out  1   copy in progress
//  done       out  1   1-cycle pulse at end of every accepted request
//  err        out  1   set with done when aborted on ROM destination; cleared at next accepted start
//  checksum   out  DW  sum mod 2^DW of bytes written by the last request
//  mem_we     out  1   to decoder_rc we
//  mem_addr   out  AW  to decoder_rc address
//  mem_din    out  DW  to decoder_rc din
//  mem_dout   in   DW  from decoder_rc dout
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; busy=0, done=0, err=0, checksum=0, mem_we=0, mem_addr=0, mem_din=0.
//  - Reset mid-copy: mem_we drops in the same instant; partially written SRAM words stay; no done pulse.
//  - States: IDLE, RD, CAP, WR, DONE.
//  - IDLE: start=1 at edge -> latch src/dst/len into cur_src/cur_dst/remaining, clear err and checksum;
//    len!=0 -> RD, len==0 -> DONE.
//  - RD: mem_addr=cur_src, mem_we=0; ROM registers data at closing edge. -> CAP.
//  - CAP: mem_addr=cur_src, mem_we=0; mem_dout valid (ROM registered, SRAM async); latch into buf at closing edge.
//    If cur_dst[AW-1]==0 -> err=1, DONE (no write). Else -> WR.
//  - WR: mem_addr=cur_dst, mem_din=buf, mem_we=1; at closing edge checksum+=buf (wrap mod 2^DW), cur_src++, cur_dst++
//    (both wrap mod 2^AW), remaining--; remaining becomes 0 -> DONE, else RD.
//  - DONE: done=1 for exactly this cycle, busy=0 -> IDLE. start in DONE is ignored.
//  - busy=1 in RD, CAP, WR only. start while busy or in DONE is ignored (not queued).
//  - Latency: len=N, no error: start edge, 3N busy cycles, then done cycle; mem_we high N cycles total.
//  - Destination check is per word, so a run wrapping 0x7F->0x00 writes up to 0x7F and aborts at 0x00.
//  - Source wrap 0x3F->0x40 (ROM into SRAM) and 0x7F->0x00 is legal.
//  - src==dst or overlapping ranges: copy proceeds in ascending order, no hazard handling.
//  - Inputs src_addr/dst_addr/len may change after start is accepted without effect.
//  - mem_we is registered/decoded from state only, never combinational from start.
// STRUCTURE
//  - Shared package mem_map_pkg: AW/DW defaults, SRAM_SEL_BIT=AW-1, ROM_BASE=0x00, SRAM_BASE=0x40, state encodings (3-bit).
//  - Single module, no sub-modules; top test wrapper instantiates mem_copy_ctrl + decoder_rc.
// TESTING (bench: mem_copy_ctrl + decoder_rc, 10 ns clock)
//  1 start src=0x00 dst=0x40 len=8 -> SRAM 0x40..0x47 = 1,1,2,3,5,8,13,21; checksum=54; done 25 cycles after start edge; err=0.
//  2 start src=0x08 dst=0x7F len=3 -> 0x7F=2 written, abort at dst 0x00; err=1, checksum=2, mem_we high exactly 1 cycle.
//  3 start len=0 -> done pulse next cycle, busy never 1, mem_we never 1, checksum=0.
//  4 after test 1, start src=0x40 dst=0x50 len=4 (SRAM->SRAM) -> 0x50..0x53 = 1,1,2,3; checksum=7.
//  5 start src=0x38 dst=0x60 len=8; pulse start again mid-copy; drive rst_n=0 in 2nd WR -> 2nd start ignored;
//    mem_we/busy drop at once; only 0x60 written (=8); all outputs at reset values.
//  6 start src=0x3E dst=0x70 len=4 after test 1 -> src wraps into SRAM: 0x70..0x73 = 14,22,1,1; checksum=38.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and copy-sequencer state encoding for the decoder_rc space.
// ROM occupies the lower half of the address space, SRAM the upper half.
package mem_map_pkg;

  localparam int unsigned AW           = 7;
  localparam int unsigned DW           = 8;
  localparam int unsigned SRAM_SEL_BIT = AW - 1;

  localparam logic [AW-1:0] ROM_BASE  = AW'(8'h00);
  localparam logic [AW-1:0] SRAM_BASE = AW'(8'h40);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } copy_state_e;

  // True when the address falls in the writable SRAM half.
  function automatic logic is_sram(input logic [AW-1:0] addr);
    return addr[SRAM_SEL_BIT];
  endfunction

endpackage

// File: rtl/mem_copy_ctrl.sv
// Block-copy sequencer driving decoder_rc's single port: one word per RD/CAP/WR slot,
// aborting on a ROM destination and keeping a running checksum of written bytes.
module mem_copy_ctrl #(
  parameter int unsigned AW = mem_map_pkg::AW,
  parameter int unsigned DW = mem_map_pkg::DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] checksum,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  import mem_map_pkg::*;

  localparam int unsigned SEL = AW - 1;

  copy_state_e   state;
  logic [AW-1:0] cur_src;
  logic [AW-1:0] cur_dst;
  logic [AW-1:0] remaining;

  // Outputs are registered and loaded on the edge that enters the state they belong to,
  // so mem_we/mem_addr/busy always reflect the current state with no path from start.
  // mem_din doubles as the word buffer captured in CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      checksum  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_src   <= src_addr;
            cur_dst   <= dst_addr;
            remaining <= len;
            err       <= 1'b0;
            checksum  <= '0;
            if (len != '0) begin
              state    <= ST_RD;
              busy     <= 1'b1;
              mem_addr <= src_addr;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end

        // ROM registers its read data at the end of this cycle.
        ST_RD: begin
          state <= ST_CAP;
        end

        ST_CAP: begin
          mem_din <= mem_dout;
          if (!cur_dst[SEL]) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            state    <= ST_WR;
            mem_addr <= cur_dst;
            mem_we   <= 1'b1;
          end
        end

        ST_WR: begin
          mem_we    <= 1'b0;
          checksum  <= checksum + mem_din;
          cur_src   <= cur_src + AW'(1);
          cur_dst   <= cur_dst + AW'(1);
          remaining <= remaining - AW'(1);
          if (remaining == AW'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ST_RD;
            mem_addr <= cur_src + AW'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Bench for mem_copy_ctrl with a behavioural decoder_rc (registered ROM, async-read SRAM)
// and a word-by-word reference copy model.
module tb_mem_copy_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] src_addr, dst_addr, len;
  logic       busy, done, err, mem_we;
  logic [7:0] checksum, mem_din, mem_dout;
  logic [6:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sram     [64];
  logic [7:0] ref_sram [64];
  logic [7:0] rom_q;
  logic       clr_sram;

  logic [7:0] exp_sum;
  logic       exp_err;
  int         exp_words;

  int done_cyc, busy_cnt, we_cnt;
  logic done_tail;

  always #5 clk = ~clk;

  mem_copy_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  function automatic logic [7:0] rom_val(input logic [6:0] a);
    case (a)
      7'h00: rom_val = 8'd1;
      7'h01: rom_val = 8'd1;
      7'h02: rom_val = 8'd2;
      7'h03: rom_val = 8'd3;
      7'h04: rom_val = 8'd5;
      7'h05: rom_val = 8'd8;
      7'h06: rom_val = 8'd13;
      7'h07: rom_val = 8'd21;
      7'h08: rom_val = 8'd2;
      7'h38: rom_val = 8'd8;
      7'h3E: rom_val = 8'd14;
      7'h3F: rom_val = 8'd22;
      default: rom_val = 8'(({1'b0, a} * 8'd7) + 8'd3);
    endcase
  endfunction

  // decoder_rc model: ROM output registered, SRAM read combinational, SRAM write on edge.
  always @(posedge clk) begin
    rom_q <= rom_val(mem_addr);
    if (clr_sram) begin
      for (int i = 0; i < 64; i++) sram[i] <= 8'h00;
    end else if (mem_we && mem_addr[6]) begin
      sram[mem_addr[5:0]] <= mem_din;
    end
  end

  assign mem_dout = mem_addr[6] ? sram[mem_addr[5:0]] : rom_q;

  // Reference: copy words in ascending order, stop at the first ROM destination.
  task automatic ref_copy(input logic [6:0] s, input logic [6:0] d, input logic [6:0] l,
                          input int max_words);
    logic [6:0] si, di;
    logic [7:0] v;
    si = s; di = d;
    exp_sum = 8'h00; exp_err = 1'b0; exp_words = 0;
    for (int i = 0; i < int'(l) && i < max_words; i++) begin
      if (!di[6]) begin
        exp_err = 1'b1;
        break;
      end
      v = si[6] ? ref_sram[si[5:0]] : rom_val(si);
      ref_sram[di[5:0]] = v;
      exp_sum = exp_sum + v;
      exp_words++;
      si = si + 7'd1;
      di = di + 7'd1;
    end
  endtask

  function automatic int sram_diffs();
    int n = 0;
    for (int i = 0; i < 64; i++) if (sram[i] !== ref_sram[i]) n++;
    return n;
  endfunction

  function automatic int exp_done_cyc(input logic [6:0] l);
    if (l == 7'd0) return 1;
    if (exp_err)   return 3 * exp_words + 3;
    return 3 * int'(l) + 1;
  endfunction

  // Issue one request, scramble the inputs after acceptance, and observe until done.
  task automatic run_copy(input logic [6:0] s, input logic [6:0] d, input logic [6:0] l);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = 7'($urandom); dst_addr = 7'($urandom); len = 7'($urandom);
    done_cyc = 0; busy_cnt = 0; we_cnt = 0;
    for (int k = 1; k <= 420; k++) begin
      @(negedge clk);
      if (busy)   busy_cnt++;
      if (mem_we) we_cnt++;
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    @(negedge clk);
    done_tail = done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0; clr_sram = 1'b1;
    for (int i = 0; i < 64; i++) ref_sram[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({busy, done, err, mem_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: busy/done/err/we=%b expected 0000", {busy, done, err, mem_we});
    end
    n_tests++;
    if (checksum !== 8'h00 || mem_addr !== 7'h00 || mem_din !== 8'h00) begin
      n_fail++; $display("FAIL reset_bus: checksum=%h addr=%h din=%h expected 0", checksum, mem_addr, mem_din);
    end
    clr_sram = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_rom_to_sram();
    ref_copy(7'h00, 7'h40, 7'd8, 128);
    run_copy(7'h00, 7'h40, 7'd8);
    n_tests++;
    if (done_cyc !== 25 || busy_cnt !== 24 || done_tail !== 1'b0) begin
      n_fail++; $display("FAIL fib_timing: done_cyc=%0d busy=%0d tail=%b expected 25/24/0", done_cyc, busy_cnt, done_tail);
    end
    n_tests++;
    if (we_cnt !== 8 || err !== 1'b0) begin
      n_fail++; $display("FAIL fib_we_err: we=%0d err=%b expected 8/0", we_cnt, err);
    end
    n_tests++;
    if (checksum !== 8'd54 || exp_sum !== 8'd54) begin
      n_fail++; $display("FAIL fib_checksum: got %0d model %0d expected 54", checksum, exp_sum);
    end
    n_tests++;
    if (sram[0] !== 8'd1 || sram[3] !== 8'd3 || sram[6] !== 8'd13 || sram[7] !== 8'd21 || sram_diffs() != 0) begin
      n_fail++; $display("FAIL fib_data: 0x40=%0d 0x47=%0d diffs=%0d", sram[0], sram[7], sram_diffs());
    end
  endtask

  task automatic test_rom_dst_abort();
    ref_copy(7'h08, 7'h7F, 7'd3, 128);
    run_copy(7'h08, 7'h7F, 7'd3);
    n_tests++;
    if (err !== 1'b1 || checksum !== 8'd2 || we_cnt !== 1) begin
      n_fail++; $display("FAIL abort: err=%b checksum=%0d we=%0d expected 1/2/1", err, checksum, we_cnt);
    end
    n_tests++;
    if (done_cyc !== 6 || sram[63] !== 8'd2 || sram_diffs() != 0) begin
      n_fail++; $display("FAIL abort_data: done_cyc=%0d 0x7F=%0d diffs=%0d expected 6/2/0", done_cyc, sram[63], sram_diffs());
    end
  endtask

  task automatic test_zero_len();
    int extra_done = 0;
    int saw_busy = 0;
    @(negedge clk);
    start = 1'b1; src_addr = 7'h10; dst_addr = 7'h50; len = 7'd0;
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || checksum !== 8'h00) begin
      n_fail++; $display("FAIL zero_len: done=%b busy=%b err=%b cs=%0d expected 1/0/0/0", done, busy, err, checksum);
    end
    // start held through DONE must be ignored
    @(posedge clk); #1;
    start = 1'b0;
    if (done) extra_done++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy || mem_we) saw_busy++;
    end
    n_tests++;
    if (extra_done !== 0 || saw_busy !== 0) begin
      n_fail++; $display("FAIL zero_len_quiet: extra_done=%0d busy_or_we=%0d expected 0/0", extra_done, saw_busy);
    end
  endtask

  task automatic test_sram_to_sram();
    ref_copy(7'h40, 7'h50, 7'd4, 128);
    run_copy(7'h40, 7'h50, 7'd4);
    n_tests++;
    if (checksum !== 8'd7 || err !== 1'b0 || done_cyc !== 13) begin
      n_fail++; $display("FAIL sram2sram: cs=%0d err=%b done_cyc=%0d expected 7/0/13", checksum, err, done_cyc);
    end
    n_tests++;
    if (sram[16] !== 8'd1 || sram[17] !== 8'd1 || sram[18] !== 8'd2 || sram[19] !== 8'd3 || sram_diffs() != 0) begin
      n_fail++; $display("FAIL sram2sram_data: 0x50..53=%0d,%0d,%0d,%0d diffs=%0d", sram[16], sram[17], sram[18], sram[19], sram_diffs());
    end
  endtask

  task automatic test_src_wrap();
    ref_copy(7'h3E, 7'h70, 7'd4, 128);
    run_copy(7'h3E, 7'h70, 7'd4);
    n_tests++;
    if (checksum !== 8'd38 || err !== 1'b0) begin
      n_fail++; $display("FAIL src_wrap: cs=%0d err=%b expected 38/0", checksum, err);
    end
    n_tests++;
    if (sram[48] !== 8'd14 || sram[49] !== 8'd22 || sram[50] !== 8'd1 || sram[51] !== 8'd1 || sram_diffs() != 0) begin
      n_fail++; $display("FAIL src_wrap_data: 0x70..73=%0d,%0d,%0d,%0d diffs=%0d", sram[48], sram[49], sram[50], sram[51], sram_diffs());
    end
  endtask

  task automatic test_reset_mid_copy();
    logic [7:0] old61;
    int bad = 0;
    old61 = sram[33];
    ref_copy(7'h38, 7'h60, 7'd8, 1);
    @(negedge clk);
    start = 1'b1; src_addr = 7'h38; dst_addr = 7'h60; len = 7'd8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        start = 1'b1; src_addr = 7'h00; dst_addr = 7'h40; len = 7'd5;
      end else begin
        start = 1'b0;
      end
      if (k == 3 && (mem_we !== 1'b1 || mem_addr !== 7'h60)) bad++;
    end
    n_tests++;
    if (mem_we !== 1'b1 || mem_addr !== 7'h61 || busy !== 1'b1 || bad != 0) begin
      n_fail++; $display("FAIL midcopy_2nd_wr: we=%b addr=%h busy=%b early_bad=%0d expected 1/61/1/0", mem_we, mem_addr, busy, bad);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, err, mem_we} !== 4'b0000 || checksum !== 8'h00 || mem_addr !== 7'h00 || mem_din !== 8'h00) begin
      n_fail++; $display("FAIL midcopy_reset: flags=%b cs=%0d addr=%h din=%h expected 0", {busy, done, err, mem_we}, checksum, mem_addr, mem_din);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || busy || mem_we) bad++;
    end
    n_tests++;
    if (sram[32] !== 8'd8 || sram[33] !== old61 || sram_diffs() != 0 || bad != 0) begin
      n_fail++; $display("FAIL midcopy_data: 0x60=%0d 0x61=%0d(was %0d) diffs=%0d activity=%0d", sram[32], sram[33], old61, sram_diffs(), bad);
    end
  endtask

  task automatic test_random();
    logic [6:0] s, d, l;
    for (int it = 0; it < 24; it++) begin
      s = 7'($urandom_range(0, 127));
      d = ($urandom_range(0, 3) != 0) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(0, 127));
      l = 7'($urandom_range(0, 23));
      ref_copy(s, d, l, 128);
      run_copy(s, d, l);
      n_tests++;
      if (done_cyc != exp_done_cyc(l) || busy_cnt != done_cyc - 1 || done_tail !== 1'b0) begin
        n_fail++; $display("FAIL rand_timing[%0d]: s=%h d=%h l=%0d done_cyc=%0d busy=%0d exp %0d", it, s, d, l, done_cyc, busy_cnt, exp_done_cyc(l));
      end
      n_tests++;
      if (checksum !== exp_sum || err !== exp_err || we_cnt != exp_words || sram_diffs() != 0) begin
        n_fail++; $display("FAIL rand_result[%0d]: cs=%0d/%0d err=%b/%b we=%0d/%0d diffs=%0d", it, checksum, exp_sum, err, exp_err, we_cnt, exp_words, sram_diffs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rom_to_sram();
    test_rom_dst_abort();
    test_zero_len();
    test_sram_to_sram();
    test_src_wrap();
    test_reset_mid_copy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
